// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage of the 16-bit MIPS pipeline.
//   - Default datapath and register-index widths.
//   - Handshake FSM state encoding (StIdle=0, StMem=1).
//   - Bit positions of the control bundle shared with the decode/execute latches.
package mem_wb_stage_pkg;

    localparam int unsigned DefDataW = 16;
    localparam int unsigned DefRegAw = 3;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StMem  = 1'b1
    } mem_state_e;

    // Control bundle layout, identical to the upstream pipeline latches.
    localparam int unsigned CtrlMemRead  = 0;
    localparam int unsigned CtrlMemWrite = 1;
    localparam int unsigned CtrlBranch   = 2;
    localparam int unsigned CtrlRegWrite = 3;
    localparam int unsigned CtrlMemtoReg = 4;
    localparam int unsigned CtrlW        = 5;

    typedef logic [CtrlW-1:0] ctrl_t;

    function automatic logic is_mem_op(ctrl_t c);
        return c[CtrlMemRead] | c[CtrlMemWrite];
    endfunction

    // MemRead together with MemWrite behaves as a store, so only a pure read is a load.
    function automatic logic is_load(ctrl_t c);
        return c[CtrlMemRead] & ~c[CtrlMemWrite];
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Bundle of every non-clock signal of mem_wb_stage.
//   master : the environment (execute stage, data memory, register file side)
//   slave  : the mem_wb_stage itself
// Groups: EX handshake/payload (in_*), data-memory req/ack (O_Mem_*, in_Mem_*),
// branch outputs (O_PCSrc, O_BranchTarget), writeback packet (O_WB_*), O_MemErr.
interface mem_wb_stage_if
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned REG_AW = DefRegAw
) ();

    // Execute stage side
    logic              in_Valid;
    logic              O_Ready;
    logic [DATA_W-1:0] in_ALUResult;
    logic              in_Zero;
    logic [DATA_W-1:0] in_BranchTarget;
    logic [REG_AW-1:0] in_WriteRegister;
    logic [DATA_W-1:0] in_Read_Data_2;
    logic              in_MemRead;
    logic              in_MemWrite;
    logic              in_Branch;
    logic              in_RegWrite;
    logic              in_MemtoReg;

    // Branch resolution
    logic              O_PCSrc;
    logic [DATA_W-1:0] O_BranchTarget;

    // Data memory
    logic              O_Mem_Req;
    logic              O_Mem_We;
    logic [DATA_W-1:0] O_Mem_Addr;
    logic [DATA_W-1:0] O_Mem_WData;
    logic              in_Mem_Ack;
    logic [DATA_W-1:0] in_Mem_RData;

    // Writeback and status
    logic              O_WB_Valid;
    logic [REG_AW-1:0] O_WB_WriteRegister;
    logic [DATA_W-1:0] O_WB_Data;
    logic              O_MemErr;

    modport master (
        output in_Valid, in_ALUResult, in_Zero, in_BranchTarget, in_WriteRegister,
               in_Read_Data_2, in_MemRead, in_MemWrite, in_Branch, in_RegWrite, in_MemtoReg,
               in_Mem_Ack, in_Mem_RData,
        input  O_Ready, O_PCSrc, O_BranchTarget, O_Mem_Req, O_Mem_We, O_Mem_Addr,
               O_Mem_WData, O_WB_Valid, O_WB_WriteRegister, O_WB_Data, O_MemErr
    );

    modport slave (
        input  in_Valid, in_ALUResult, in_Zero, in_BranchTarget, in_WriteRegister,
               in_Read_Data_2, in_MemRead, in_MemWrite, in_Branch, in_RegWrite, in_MemtoReg,
               in_Mem_Ack, in_Mem_RData,
        output O_Ready, O_PCSrc, O_BranchTarget, O_Mem_Req, O_Mem_We, O_Mem_Addr,
               O_Mem_WData, O_WB_Valid, O_WB_WriteRegister, O_WB_Data, O_MemErr
    );

endinterface

// File: rtl/mem_wb_stage_mem_handshake_fsm.sv
// Data-memory handshake controller for mem_wb_stage.
// Owns the idle/memory state, the request line, the access timeout counter and the
// sticky timeout error.
//   clk, rst   : clock, synchronous active-high reset
//   start_i    : a memory op is accepted this cycle (only meaningful when idle)
//   ack_i      : memory acknowledge; only honoured while the request is up
//   idle_o     : stage can accept an instruction
//   req_o      : memory request, held until acknowledged
//   done_o     : acknowledge taken this cycle (read data valid now)
//   mem_err_o  : sticky timeout flag, cleared only by rst
module mem_wb_stage_mem_handshake_fsm
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic ack_i,
    output logic idle_o,
    output logic req_o,
    output logic done_o,
    output logic mem_err_o
);

    localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(MEM_TIMEOUT);
    localparam logic TimeoutEn = (MEM_TIMEOUT != 0);

    mem_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StMem;
                end
            end
            StMem: begin
                if (ack_i) begin
                    state_d = StIdle;
                end
                // Every cycle spent in StMem counts, including the ack cycle.
                cnt_d = (cnt_q != CntMax) ? cnt_q + 1'b1 : cnt_q;
                if (TimeoutEn && (cnt_d == CntMax)) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign idle_o    = (state_q == StIdle);
    assign req_o     = (state_q == StMem);
    assign done_o    = req_o & ack_i;
    assign mem_err_o = err_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage of the 16-bit MIPS pipeline.
// Latches the execute results at accept, resolves beq-type branches, runs loads/stores
// through the req/ack memory handshake (stalling EX via O_Ready) and emits a one-cycle
// writeback packet.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_wb_stage_if.slave carrying the EX handshake, branch outputs,
//              data-memory req/ack, writeback packet and O_MemErr
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned REG_AW      = DefRegAw,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input logic           clk,
    input logic           rst,
    mem_wb_stage_if.slave bus
);

    ctrl_t ex_ctrl;
    logic  fsm_idle, fsm_req, fsm_done, fsm_err;
    logic  accept, start_mem;

    // EX/MEM latch
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [REG_AW-1:0] wreg_q, wreg_d;
    logic              we_q, we_d;
    logic              load_q, load_d;
    logic              regwrite_q, regwrite_d;
    logic              memtoreg_q, memtoreg_d;

    // Branch outputs
    logic              pcsrc_q, pcsrc_d;
    logic [DATA_W-1:0] bt_q, bt_d;

    // Writeback packet
    logic              wb_valid_q, wb_valid_d;
    logic [REG_AW-1:0] wb_reg_q, wb_reg_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;

    always_comb begin
        ex_ctrl               = '0;
        ex_ctrl[CtrlMemRead]  = bus.in_MemRead;
        ex_ctrl[CtrlMemWrite] = bus.in_MemWrite;
        ex_ctrl[CtrlBranch]   = bus.in_Branch;
        ex_ctrl[CtrlRegWrite] = bus.in_RegWrite;
        ex_ctrl[CtrlMemtoReg] = bus.in_MemtoReg;
    end

    assign accept    = bus.in_Valid & fsm_idle;
    assign start_mem = accept & is_mem_op(ex_ctrl);

    mem_wb_stage_mem_handshake_fsm #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_mem),
        .ack_i     (bus.in_Mem_Ack),
        .idle_o    (fsm_idle),
        .req_o     (fsm_req),
        .done_o    (fsm_done),
        .mem_err_o (fsm_err)
    );

    always_comb begin
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wreg_d     = wreg_q;
        we_d       = we_q;
        load_d     = load_q;
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        bt_d       = bt_q;
        pcsrc_d    = 1'b0;
        wb_valid_d = 1'b0;
        wb_reg_d   = wb_reg_q;
        wb_data_d  = wb_data_q;

        if (accept) begin
            addr_d     = bus.in_ALUResult;
            wdata_d    = bus.in_Read_Data_2;
            wreg_d     = bus.in_WriteRegister;
            we_d       = ex_ctrl[CtrlMemWrite];
            load_d     = is_load(ex_ctrl);
            regwrite_d = ex_ctrl[CtrlRegWrite];
            memtoreg_d = ex_ctrl[CtrlMemtoReg];
            bt_d       = bus.in_BranchTarget;
            pcsrc_d    = ex_ctrl[CtrlBranch] & bus.in_Zero;
            // Non-memory ops write back straight from the accept cycle.
            if (!is_mem_op(ex_ctrl)) begin
                wb_valid_d = ex_ctrl[CtrlRegWrite];
                wb_reg_d   = bus.in_WriteRegister;
                wb_data_d  = bus.in_ALUResult;
            end
        end else if (fsm_done && load_q && regwrite_q) begin
            // Read data is only valid in the ack cycle, so capture it here.
            wb_valid_d = 1'b1;
            wb_reg_d   = wreg_q;
            wb_data_d  = memtoreg_q ? bus.in_Mem_RData : addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            wreg_q     <= '0;
            we_q       <= 1'b0;
            load_q     <= 1'b0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            bt_q       <= '0;
            pcsrc_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_reg_q   <= '0;
            wb_data_q  <= '0;
        end else begin
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wreg_q     <= wreg_d;
            we_q       <= we_d;
            load_q     <= load_d;
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            bt_q       <= bt_d;
            pcsrc_q    <= pcsrc_d;
            wb_valid_q <= wb_valid_d;
            wb_reg_q   <= wb_reg_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign bus.O_Ready            = fsm_idle;
    assign bus.O_PCSrc            = pcsrc_q;
    assign bus.O_BranchTarget     = bt_q;
    assign bus.O_Mem_Req          = fsm_req;
    assign bus.O_Mem_We           = we_q;
    assign bus.O_Mem_Addr         = addr_q;
    assign bus.O_Mem_WData        = wdata_q;
    assign bus.O_WB_Valid         = wb_valid_q;
    assign bus.O_WB_WriteRegister = wb_reg_q;
    assign bus.O_WB_Data          = wb_data_q;
    assign bus.O_MemErr           = fsm_err;

endmodule
